lsu: RTL and testbench

LSU -- requirements
Module: lsu

---
 rtl/lsu_if.sv | 21 ++
 rtl/lsu.sv | 177 +++++++++++++++++
 tb/tb_lsu.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lsu_if.sv
// Memory-side bus between the LSU (master) and a word-wide memory (slave).
// Address, write data and byte enables are held stable while req is high.
interface lsu_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req, we, addr, wdata, be,
    input  ack, rdata
  );

  modport slave (
    input  req, we, addr, wdata, be,
    output ack, rdata
  );
endinterface

// File: rtl/lsu.sv
// Load/store unit: turns one core access into one word-aligned bus transaction
// with byte lanes, alignment checking, load extension and an ack timeout.
module lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic        memrw_i,
  input  logic [1:0]  memword_i,
  input  logic        memsign_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] rdata_o,
  output logic        stall_o,
  output logic        done_o,
  output logic [1:0]  err_o,
  lsu_if.master       bus
);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;

  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        we_q, we_d;
  logic [1:0]  word_q, word_d;
  logic        sign_q, sign_d;
  logic [1:0]  off_q, off_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  err_q, err_d;

  logic        legal;
  logic [3:0]  be_new;
  logic [31:0] wdata_new;
  logic [31:0] shifted;
  logic [31:0] load_val;

  // Size/alignment decode of the incoming request, with lane placement.
  always_comb begin
    legal     = 1'b0;
    be_new    = 4'b0000;
    wdata_new = wdata_i;
    case (memword_i)
      2'b00: begin
        legal     = 1'b1;
        be_new    = 4'b0001 << addr_i[1:0];
        wdata_new = {4{wdata_i[7:0]}};
      end
      2'b01: begin
        legal     = ~addr_i[0];
        be_new    = addr_i[1] ? 4'b1100 : 4'b0011;
        wdata_new = {2{wdata_i[15:0]}};
      end
      2'b10: begin
        legal     = (addr_i[1:0] == 2'b00);
        be_new    = 4'b1111;
        wdata_new = wdata_i;
      end
      default: begin
        legal = 1'b0;
      end
    endcase
  end

  // memsign=1 selects zero extension, 0 selects sign extension.
  always_comb begin
    shifted  = bus.rdata >> {off_q, 3'b000};
    load_val = shifted;
    case (word_q)
      2'b00:   load_val = sign_q ? {24'h0, shifted[7:0]}
                                 : {{24{shifted[7]}}, shifted[7:0]};
      2'b01:   load_val = sign_q ? {16'h0, shifted[15:0]}
                                 : {{16{shifted[15]}}, shifted[15:0]};
      default: load_val = shifted;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    word_d  = word_q;
    sign_d  = sign_q;
    off_d   = off_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (legal) begin
            we_d    = memrw_i;
            word_d  = memword_i;
            sign_d  = memsign_i;
            off_d   = addr_i[1:0];
            addr_d  = {addr_i[31:2], 2'b00};
            wdata_d = wdata_new;
            be_d    = be_new;
            cnt_d   = 16'd0;
            err_d   = 2'b00;
            state_d = REQ;
          end else begin
            err_d   = 2'b01;
            state_d = RESP;
          end
        end
      end
      REQ: begin
        // An ack in the final allowed cycle still wins over the timeout.
        if (bus.ack) begin
          err_d   = 2'b00;
          if (!we_q) rdata_d = load_val;
          state_d = RESP;
        end else if (cnt_q == TO_LAST) begin
          err_d   = 2'b10;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      RESP: begin
        err_d   = 2'b00;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      we_q    <= 1'b0;
      word_q  <= 2'b00;
      sign_q  <= 1'b0;
      off_q   <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      be_q    <= 4'h0;
      rdata_q <= 32'h0;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      word_q  <= word_d;
      sign_q  <= sign_d;
      off_q   <= off_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign bus.req   = (state_q == REQ);
  assign bus.we    = we_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.be    = be_q;

  assign rdata_o = rdata_q;
  assign done_o  = (state_q == RESP);
  assign err_o   = (state_q == RESP) ? err_q : 2'b00;
  assign stall_o = (state_q == REQ) || ((state_q == IDLE) && start_i && legal);

endmodule

// File: tb/tb_lsu.sv
// Directed bench for the LSU: inputs change and outputs are sampled on the
// falling clock edge, with the bus slave played by hand.
module tb_lsu;
  logic        clk;
  logic        rst_n;
  logic        start;
  logic        memrw;
  logic [1:0]  memword;
  logic        memsign;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        done;
  logic [1:0]  err;

  int checkCount;
  int errorCount;

  lsu_if busIf ();

  lsu #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (start),
    .memrw_i   (memrw),
    .memword_i (memword),
    .memsign_i (memsign),
    .addr_i    (addr),
    .wdata_i   (wdata),
    .rdata_o   (rdata),
    .stall_o   (stall),
    .done_o    (done),
    .err_o     (err),
    .bus       (busIf.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic rw, input logic [1:0] w,
                               input logic sg, input logic [31:0] a, input logic [31:0] d);
    start   = s;
    memrw   = rw;
    memword = w;
    memsign = sg;
    addr    = a;
    wdata   = d;
  endtask

  initial begin
    checkCount   = 0;
    errorCount   = 0;
    rst_n        = 1'b0;
    busIf.ack    = 1'b0;
    busIf.rdata  = 32'h0;
    applyStimulus(1'b0, 1'b0, 2'b00, 1'b0, 32'h0, 32'h0);

    #3;
    checkOutput("rst_req",   busIf.req,   32'h0);
    checkOutput("rst_we",    busIf.we,    32'h0);
    checkOutput("rst_addr",  busIf.addr,  32'h0);
    checkOutput("rst_wdata", busIf.wdata, 32'h0);
    checkOutput("rst_be",    busIf.be,    32'h0);
    checkOutput("rst_rdata", rdata,       32'h0);
    checkOutput("rst_done",  done,        32'h0);
    checkOutput("rst_err",   err,         32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("[TB] load byte signed");
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_1003, 32'h0);
    #1;
    checkOutput("lb_stall0", stall, 32'h1);
    checkOutput("lb_req0",   busIf.req, 32'h0);
    @(negedge clk);
    checkOutput("lb_req1",   busIf.req,  32'h1);
    checkOutput("lb_addr",   busIf.addr, 32'h0000_1000);
    checkOutput("lb_be",     busIf.be,   32'h8);
    checkOutput("lb_we",     busIf.we,   32'h0);
    checkOutput("lb_stall1", stall,      32'h1);
    checkOutput("lb_done1",  done,       32'h0);
    busIf.ack   = 1'b1;
    busIf.rdata = 32'h80AA_BBCC;
    @(negedge clk);
    checkOutput("lb_done2",  done,  32'h1);
    checkOutput("lb_err",    err,   32'h0);
    checkOutput("lb_rdata",  rdata, 32'hFFFF_FF80);
    checkOutput("lb_stall2", stall, 32'h0);
    checkOutput("lb_req2",   busIf.req, 32'h0);
    busIf.ack = 1'b0;
    start     = 1'b0;
    @(negedge clk);
    checkOutput("lb_done3", done, 32'h0);

    $display("[TB] store half with ack in the last allowed cycle");
    applyStimulus(1'b1, 1'b1, 2'b01, 1'b0, 32'h0000_2002, 32'h1234_ABCD);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("sh_req",   busIf.req,   32'h1);
      checkOutput("sh_we",    busIf.we,    32'h1);
      checkOutput("sh_be",    busIf.be,    32'hC);
      checkOutput("sh_wdata", busIf.wdata, 32'hABCD_ABCD);
      checkOutput("sh_addr",  busIf.addr,  32'h0000_2000);
      checkOutput("sh_done",  done,        32'h0);
      if (i == 3) busIf.ack = 1'b1;
    end
    @(negedge clk);
    checkOutput("sh_done_end", done,  32'h1);
    checkOutput("sh_err",      err,   32'h0);
    checkOutput("sh_rdata",    rdata, 32'hFFFF_FF80);
    busIf.ack = 1'b0;
    start     = 1'b0;
    @(negedge clk);

    $display("[TB] store byte lane replication");
    applyStimulus(1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0011, 32'h0000_005A);
    @(negedge clk);
    checkOutput("sb_be",    busIf.be,    32'h2);
    checkOutput("sb_wdata", busIf.wdata, 32'h5A5A_5A5A);
    checkOutput("sb_addr",  busIf.addr,  32'h0000_0010);
    busIf.ack = 1'b1;
    @(negedge clk);
    checkOutput("sb_done", done, 32'h1);
    busIf.ack = 1'b0;
    start     = 1'b0;
    @(negedge clk);

    $display("[TB] misaligned word load");
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_3001, 32'h0);
    #1;
    checkOutput("mis_stall0", stall,     32'h0);
    checkOutput("mis_req0",   busIf.req, 32'h0);
    @(negedge clk);
    checkOutput("mis_done", done,      32'h1);
    checkOutput("mis_err",  err,       32'h1);
    checkOutput("mis_req1", busIf.req, 32'h0);
    checkOutput("mis_stall1", stall,   32'h0);
    start = 1'b0;
    @(negedge clk);
    checkOutput("mis_done2", done, 32'h0);
    checkOutput("mis_err2",  err,  32'h0);

    $display("[TB] illegal size");
    applyStimulus(1'b1, 1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0);
    #1;
    checkOutput("ill_stall", stall, 32'h0);
    @(negedge clk);
    checkOutput("ill_err", err,       32'h1);
    checkOutput("ill_req", busIf.req, 32'h0);
    start = 1'b0;
    @(negedge clk);

    $display("[TB] timeout");
    applyStimulus(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_5000, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checkOutput("to_req",  busIf.req, 32'h1);
      checkOutput("to_done", done,      32'h0);
    end
    @(negedge clk);
    checkOutput("to_done_end", done,      32'h1);
    checkOutput("to_err",      err,       32'h2);
    checkOutput("to_req_end",  busIf.req, 32'h0);
    checkOutput("to_rdata",    rdata,     32'hFFFF_FF80);
    start = 1'b0;
    @(negedge clk);

    $display("[TB] reset during request");
    applyStimulus(1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_6000, 32'h0);
    @(negedge clk);
    checkOutput("rr_req1", busIf.req, 32'h1);
    #2;
    rst_n = 1'b0;
    start = 1'b0;
    #1;
    checkOutput("rr_req_async", busIf.req, 32'h0);
    checkOutput("rr_rdata",     rdata,     32'h0);
    @(negedge clk);
    rst_n     = 1'b1;
    busIf.ack = 1'b1;
    @(negedge clk);
    checkOutput("rr_done",  done,      32'h0);
    checkOutput("rr_req2",  busIf.req, 32'h0);
    checkOutput("rr_stall", stall,     32'h0);
    busIf.ack = 1'b0;
    @(negedge clk);
    checkOutput("rr_done2", done, 32'h0);

    $display("[TB] back-to-back");
    applyStimulus(1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_4002, 32'h0);
    @(negedge clk);
    checkOutput("bb_be", busIf.be, 32'hC);
    busIf.ack   = 1'b1;
    busIf.rdata = 32'hF00D_0000;
    @(negedge clk);
    checkOutput("bb_done",  done,  32'h1);
    checkOutput("bb_rdata", rdata, 32'h0000_F00D);
    busIf.ack = 1'b0;
    applyStimulus(1'b1, 1'b1, 2'b10, 1'b0, 32'h0000_7000, 32'hDEAD_BEEF);
    @(negedge clk);
    checkOutput("bb_idle_req",   busIf.req, 32'h0);
    checkOutput("bb_idle_stall", stall,     32'h1);
    checkOutput("bb_idle_done",  done,      32'h0);
    @(negedge clk);
    checkOutput("bb_req2",   busIf.req,   32'h1);
    checkOutput("bb_we2",    busIf.we,    32'h1);
    checkOutput("bb_be2",    busIf.be,    32'hF);
    checkOutput("bb_wdata2", busIf.wdata, 32'hDEAD_BEEF);
    busIf.ack = 1'b1;
    @(negedge clk);
    checkOutput("bb_done2",  done,  32'h1);
    checkOutput("bb_rdata2", rdata, 32'h0000_F00D);
    busIf.ack = 1'b0;
    start     = 1'b0;
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end
endmodule
